// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular buffer accepting up to FETCH_WIDTH instructions
// per push and presenting the oldest ISSUE_WIDTH entries to decode.
module inst_fetch_queue #(
  parameter  int DEPTH       = 8,
  parameter  int FETCH_WIDTH = 2,
  parameter  int ISSUE_WIDTH = 2,
  localparam int PW  = $clog2(DEPTH),
  localparam int CW  = $clog2(DEPTH + 1),
  localparam int FCW = $clog2(FETCH_WIDTH + 1),
  localparam int ICW = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_valid,
  input  logic [FCW-1:0]           push_count,
  input  logic [FETCH_WIDTH*32-1:0] push_pc,
  input  logic [FETCH_WIDTH*32-1:0] push_inst,
  input  logic [FETCH_WIDTH-1:0]   push_ex,
  output logic                     push_ready,
  output logic [ISSUE_WIDTH-1:0]   pop_valid,
  output logic [ISSUE_WIDTH*32-1:0] pop_pc,
  output logic [ISSUE_WIDTH*32-1:0] pop_inst,
  output logic [ISSUE_WIDTH-1:0]   pop_ex,
  input  logic [ICW-1:0]           pop_count,
  output logic [CW-1:0]            count,
  output logic                     empty,
  output logic                     full
);

  logic [PW-1:0]    head, tail;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [DEPTH-1:0] ex_mem;
  logic [CW-1:0]    push_n, pop_n;
  logic             do_push;

  // Readiness looks only at registered occupancy so a full group always fits.
  assign push_ready = (int'(count) + FETCH_WIDTH <= DEPTH);
  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));

  always_comb begin
    do_push = push_valid && push_ready && !flush;
    push_n  = (CW'(push_count) > CW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH) : CW'(push_count);
    if (!do_push) push_n = '0;
    pop_n   = (CW'(pop_count) > count) ? count : CW'(pop_count);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(push_n);
      head  <= head + PW'(pop_n);
      count <= count + push_n - pop_n;
    end
  end

  // Storage carries no reset; validity is tracked purely by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (CW'(i) < push_n) begin
        pc_mem[tail + PW'(i)]   <= push_pc[32*i +: 32];
        inst_mem[tail + PW'(i)] <= push_inst[32*i +: 32];
        ex_mem[tail + PW'(i)]   <= push_ex[i];
      end
    end
  end

  for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_pop
    logic [PW-1:0] rd;
    assign rd                 = head + PW'(i);
    assign pop_valid[i]       = (count > CW'(i));
    assign pop_pc[32*i +: 32]   = pop_valid[i] ? pc_mem[rd]   : '0;
    assign pop_inst[32*i +: 32] = pop_valid[i] ? inst_mem[rd] : '0;
    assign pop_ex[i]          = pop_valid[i] ? ex_mem[rd]   : 1'b0;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int DEPTH = 8, FW = 2, IW = 2;

  logic        clk = 1'b0;
  logic        reset, flush, push_valid;
  logic [1:0]  push_count, push_ex, pop_count;
  logic [63:0] push_pc, push_inst;
  logic        push_ready, empty, full;
  logic [1:0]  pop_valid, pop_ex;
  logic [63:0] pop_pc, pop_inst;
  logic [3:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
  } ent_t;
  ent_t q[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .push_valid(push_valid),
    .push_count(push_count), .push_pc(push_pc), .push_inst(push_inst),
    .push_ex(push_ex), .push_ready(push_ready), .pop_valid(pop_valid),
    .pop_pc(pop_pc), .pop_inst(pop_inst), .pop_ex(pop_ex),
    .pop_count(pop_count), .count(count), .empty(empty), .full(full)
  );

  task automatic idle();
    flush = 0; push_valid = 0; push_count = 0; push_pc = '0;
    push_inst = '0; push_ex = '0; pop_count = 0;
  endtask

  // Advance one clock, updating the reference model from the applied inputs.
  task automatic step();
    int n, p;
    ent_t e;
    n = q.size();
    if (flush) q.delete();
    else begin
      p = (int'(pop_count) < n) ? int'(pop_count) : n;
      repeat (p) q.delete(0);
      if (push_valid && (DEPTH - n >= FW))
        for (int i = 0; i < int'(push_count); i++) begin
          e.pc = push_pc[32*i +: 32]; e.inst = push_inst[32*i +: 32]; e.ex = push_ex[i];
          q.push_back(e);
        end
    end
    @(posedge clk); #1;
  endtask

  task automatic push_group(input int cnt, input logic [31:0] pc0, input logic [1:0] ex);
    idle();
    push_valid = 1; push_count = 2'(cnt); push_ex = ex;
    push_pc   = {pc0 + 32'd4, pc0};
    push_inst = {(pc0 + 32'd4) ^ 32'h5A5A_0000, pc0 ^ 32'h5A5A_0000};
    step();
    idle();
  endtask

  task automatic pop_n(input int n);
    idle(); pop_count = 2'(n); step(); idle();
  endtask

  task automatic apply_reset();
    idle();
    reset = 1;
    @(posedge clk); #1;
    q.delete();
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || push_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags got cnt=%0d e=%b f=%b r=%b exp cnt=0 e=1 f=0 r=1", count, empty, full, push_ready);
    end
    checks++;
    if (pop_valid !== 2'b00 || pop_pc !== 64'd0 || pop_inst !== 64'd0 || pop_ex !== 2'b00) begin
      errors++;
      $display("FAIL reset_pop got v=%b pc=%h inst=%h ex=%b exp all zero", pop_valid, pop_pc, pop_inst, pop_ex);
    end
  endtask

  task automatic test_basic_push();
    apply_reset();
    idle();
    push_valid = 1; push_count = 2;
    push_pc = {32'hBFC00004, 32'hBFC00000}; push_inst = {32'h1111_2222, 32'h3333_4444};
    step(); idle();
    checks++;
    if (count !== 4'd2 || pop_valid !== 2'b11) begin
      errors++; $display("FAIL basic_count got cnt=%0d v=%b exp cnt=2 v=11", count, pop_valid);
    end
    checks++;
    if (pop_pc !== {32'hBFC00004, 32'hBFC00000} || pop_inst !== {32'h1111_2222, 32'h3333_4444}) begin
      errors++; $display("FAIL basic_data got pc=%h inst=%h exp pc=bfc00004bfc00000", pop_pc, pop_inst);
    end
  endtask

  task automatic test_zero_push();
    // Queue holds 2 entries from the previous scenario.
    idle(); push_valid = 1; push_count = 0; push_pc = {32'hDEAD, 32'hBEEF};
    step(); idle();
    checks++;
    if (count !== 4'd2 || pop_pc[31:0] !== 32'hBFC00000) begin
      errors++; $display("FAIL zero_push got cnt=%0d pc0=%h exp cnt=2 pc0=bfc00000", count, pop_pc[31:0]);
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int g = 0; g < 4; g++) push_group(2, 32'h2000 + 32'(g * 8), 2'b00);
    checks++;
    if (count !== 4'd8 || full !== 1'b1 || push_ready !== 1'b0) begin
      errors++; $display("FAIL full_state got cnt=%0d f=%b r=%b exp cnt=8 f=1 r=0", count, full, push_ready);
    end
    idle(); push_valid = 1; push_count = 2; push_pc = {32'h9999, 32'h8888};
    repeat (3) step();
    idle();
    checks++;
    if (count !== 4'd8 || pop_pc !== {32'h2004, 32'h2000}) begin
      errors++; $display("FAIL full_hold got cnt=%0d pc=%h exp cnt=8 pc=0000200400002000", count, pop_pc);
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (pop_pc !== {32'h2004 + 32'(g * 8), 32'h2000 + 32'(g * 8)}) begin
        errors++; $display("FAIL full_order got pc=%h at group %0d", pop_pc, g);
      end
      pop_n(2);
    end
    checks++;
    if (empty !== 1'b1 || pop_valid !== 2'b00) begin
      errors++; $display("FAIL full_drain got e=%b v=%b exp e=1 v=00", empty, pop_valid);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    apply_reset();
    for (int g = 0; g < 3; g++) push_group(2, 32'h40 + 32'(g * 8), 2'b00);
    repeat (3) pop_n(2);
    push_group(2, 32'h100, 2'b00);
    push_group(2, 32'h108, 2'b00);
    for (int k = 0; k < 4; k++) begin
      exp_pc = 32'h100 + 32'(k * 4);
      checks++;
      if (pop_pc[31:0] !== exp_pc || pop_valid[0] !== 1'b1) begin
        errors++; $display("FAIL wrap_order got pc=%h v=%b exp pc=%h", pop_pc[31:0], pop_valid, exp_pc);
      end
      pop_n(1);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    apply_reset();
    for (int g = 0; g < 3; g++) push_group(2, 32'h300 + 32'(g * 8), 2'b00);
    idle();
    push_valid = 1; push_count = 2; push_pc = {32'h31C, 32'h318}; pop_count = 1;
    step(); idle();
    checks++;
    if (count !== 4'd7 || push_ready !== 1'b0 || pop_pc[31:0] !== 32'h304) begin
      errors++; $display("FAIL pushpop got cnt=%0d r=%b pc0=%h exp cnt=7 r=0 pc0=304", count, push_ready, pop_pc[31:0]);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    push_group(2, 32'h500, 2'b00);
    push_group(2, 32'h508, 2'b00);
    push_group(1, 32'h510, 2'b00);
    idle();
    flush = 1; push_valid = 1; push_count = 2; push_pc = {32'hF4, 32'hF0}; pop_count = 2;
    step(); idle();
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || pop_valid !== 2'b00 || pop_pc !== 64'd0) begin
      errors++; $display("FAIL flush got cnt=%0d e=%b v=%b pc=%h exp cnt=0 e=1 v=00 pc=0", count, empty, pop_valid, pop_pc);
    end
    step();
    checks++;
    if (count !== 4'd0 || pop_valid !== 2'b00) begin
      errors++; $display("FAIL flush_hold got cnt=%0d v=%b exp cnt=0 v=00", count, pop_valid);
    end
  endtask

  task automatic test_pop_clamp();
    apply_reset();
    push_group(1, 32'h700, 2'b00);
    idle();
    push_valid = 1; push_count = 1; push_pc = {32'h0, 32'h704}; push_ex = 2'b01; pop_count = 2;
    step(); idle();
    checks++;
    if (count !== 4'd1 || pop_valid !== 2'b01 || pop_ex !== 2'b01 || pop_pc !== {32'h0, 32'h704}) begin
      errors++; $display("FAIL clamp got cnt=%0d v=%b ex=%b pc=%h exp cnt=1 v=01 ex=01 pc=704", count, pop_valid, pop_ex, pop_pc);
    end
    pop_n(2);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL clamp_empty got cnt=%0d e=%b exp cnt=0 e=1", count, empty);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    push_group(2, 32'h900, 2'b11);
    push_group(2, 32'h908, 2'b00);
    idle(); push_valid = 1; push_count = 2; pop_count = 1;
    #2 reset = 1;
    #1;
    checks++;
    if (count !== 4'd0 || pop_valid !== 2'b00 || push_ready !== 1'b1 || pop_pc !== 64'd0) begin
      errors++; $display("FAIL async_reset got cnt=%0d v=%b r=%b pc=%h exp cnt=0 v=00 r=1 pc=0", count, pop_valid, push_ready, pop_pc);
    end
    q.delete();
    idle();
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] epc, einst;
    logic        eex, ev;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (count !== 4'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
          push_ready !== (DEPTH - q.size() >= FW)) begin
        errors++;
        $display("FAIL rand_status cyc %0d got cnt=%0d e=%b f=%b r=%b exp cnt=%0d", c, count, empty, full, push_ready, q.size());
      end
      for (int i = 0; i < IW; i++) begin
        ev = (i < q.size());
        epc = ev ? q[i].pc : 32'd0; einst = ev ? q[i].inst : 32'd0; eex = ev ? q[i].ex : 1'b0;
        checks++;
        if (pop_valid[i] !== ev || pop_pc[32*i +: 32] !== epc || pop_inst[32*i +: 32] !== einst || pop_ex[i] !== eex) begin
          errors++;
          $display("FAIL rand_lane%0d cyc %0d got v=%b pc=%h inst=%h ex=%b exp v=%b pc=%h inst=%h ex=%b",
                   i, c, pop_valid[i], pop_pc[32*i +: 32], pop_inst[32*i +: 32], pop_ex[i], ev, epc, einst, eex);
        end
      end
      flush      = ($urandom_range(0, 24) == 0);
      push_valid = $urandom_range(0, 99) < 60;
      push_count = 2'($urandom_range(0, 2));
      push_pc    = {$urandom, $urandom};
      push_inst  = {$urandom, $urandom};
      push_ex    = 2'($urandom_range(0, 3));
      pop_count  = 2'($urandom_range(0, 2));
      step();
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_basic_push();
    test_zero_push();
    test_full();
    test_wrap();
    test_push_pop_same_cycle();
    test_flush();
    test_pop_clamp();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
